// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : regfile_pkg                                                  |
// | Purpose   : Shared defaults and helpers for the 2R1W register file.      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package regfile_pkg;

  localparam int N_DEF     = 32;
  localparam int WORDS_DEF = 32;
  localparam int M_DEF     = 5;
  localparam int R0_IDX    = 0;

  // A read at the address being written this cycle sees the write data.
  function automatic logic bypass_match(input logic bypass_en,
                                        input logic we,
                                        input logic addr_eq);
    return bypass_en && we && addr_eq;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : regfile_scoreboard                                           |
// | Purpose   : Pending-write bit per register plus per-read-port busy flags.|
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WORDS   = WORDS_DEF,
  parameter int M       = M_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [M-1:0] w,
  input  logic         issue,
  input  logic [M-1:0] id,
  input  logic [M-1:0] r1,
  input  logic [M-1:0] r2,
  output logic         busy1,
  output logic         busy2
);

  logic [WORDS-1:0] r_busy;
  logic             w_sel1;
  logic             w_sel2;
  logic             w_is_r0_1;
  logic             w_is_r0_2;

  // Set is evaluated first so a new producer overrides the retiring one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (issue && (id == M'(i)) && !(ZERO_R0 && (i == R0_IDX))) begin
          r_busy[i] <= 1'b1;
        end else if (we && (w == M'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Address-decoded select: out-of-range addresses fall through to 0.
  always_comb begin
    w_sel1 = 1'b0;
    w_sel2 = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (r1 == M'(i)) w_sel1 = r_busy[i];
      if (r2 == M'(i)) w_sel2 = r_busy[i];
    end
  end

  assign w_is_r0_1 = ZERO_R0 && (r1 == M'(R0_IDX));
  assign w_is_r0_2 = ZERO_R0 && (r2 == M'(R0_IDX));

  assign busy1 = w_sel1 && !w_is_r0_1 && !bypass_match(BYPASS, we, w == r1);
  assign busy2 = w_sel2 && !w_is_r0_2 && !bypass_match(BYPASS, we, w == r2);

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : regfile_2r1w_sb                                              |
// | Purpose   : Clocked 2R1W register file, write bypass, pending scoreboard.|
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int M       = M_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in0,
  input  logic [M-1:0] w,
  input  logic         we,
  input  logic [M-1:0] r1,
  input  logic         re1,
  input  logic [M-1:0] r2,
  input  logic         re2,
  input  logic         issue,
  input  logic [M-1:0] id,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic         busy1,
  output logic         busy2
);

  logic [N-1:0] r_mem [WORDS];
  logic [N-1:0] r_out1;
  logic [N-1:0] r_out2;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;
  logic [N-1:0] w_mem1;
  logic [N-1:0] w_mem2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (we && (w == M'(i)) && !(ZERO_R0 && (i == R0_IDX))) begin
          r_mem[i] <= in0;
        end
      end
    end
  end

  always_comb begin
    w_mem1 = '0;
    w_mem2 = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r1 == M'(i)) w_mem1 = r_mem[i];
      if (r2 == M'(i)) w_mem2 = r_mem[i];
    end
  end

  // R0 check precedes bypass so a discarded write to R0 never leaks through.
  always_comb begin
    w_rd1 = w_mem1;
    w_rd2 = w_mem2;
    if (ZERO_R0 && (r1 == M'(R0_IDX))) begin
      w_rd1 = '0;
    end else if (bypass_match(BYPASS, we, w == r1)) begin
      w_rd1 = in0;
    end
    if (ZERO_R0 && (r2 == M'(R0_IDX))) begin
      w_rd2 = '0;
    end else if (bypass_match(BYPASS, we, w == r2)) begin
      w_rd2 = in0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out1 <= '0;
      r_out2 <= '0;
    end else begin
      if (re1) r_out1 <= w_rd1;
      if (re2) r_out2 <= w_rd2;
    end
  end

  assign out1 = r_out1;
  assign out2 = r_out2;

  regfile_scoreboard #(
    .WORDS   (WORDS),
    .M       (M),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .w     (w),
    .issue (issue),
    .id    (id),
    .r1    (r1),
    .r2    (r2),
    .busy1 (busy1),
    .busy2 (busy2)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_regfile_2r1w_sb                                           |
// | Purpose   : Scoreboard bench with a behavioural register-file model.     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in0;
  logic [4:0]  w, r1, r2, id;
  logic        we, re1, re2, issue;
  logic [31:0] out1, out2;
  logic        busy1, busy2;

  always #5 clk = ~clk;

  regfile_2r1w_sb #(
    .N(32), .WORDS(32), .M(5), .ZERO_R0(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in0(in0), .w(w), .we(we),
    .r1(r1), .re1(re1), .r2(r2), .re2(re2), .issue(issue), .id(id),
    .out1(out1), .out2(out2), .busy1(busy1), .busy2(busy2)
  );

  typedef struct packed {
    logic [31:0] o1;
    logic [31:0] o2;
  } out_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] d;
    logic        e1;
    logic [4:0]  ra1;
    logic        e2;
    logic [4:0]  ra2;
    logic        iss;
    logic [4:0]  idd;
  } stim_t;

  out_t       q_out[$];
  logic [1:0] q_busy[$];
  int         checks = 0;
  int         errors = 0;

  // Reference state: architectural contents, pending set, output latches.
  logic [31:0] m_mem[32];
  bit          m_busy[32];
  logic [31:0] m_o1, m_o2;
  out_t        pend;
  bit          have_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic stim_t st(input logic we_i, input logic [4:0] wa, input logic [31:0] d,
                               input logic e1, input logic [4:0] ra1,
                               input logic e2, input logic [4:0] ra2,
                               input logic iss, input logic [4:0] idd);
    stim_t s;
    s.we = we_i; s.wa = wa; s.d = d; s.e1 = e1; s.ra1 = ra1;
    s.e2 = e2; s.ra2 = ra2; s.iss = iss; s.idd = idd;
    return s;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a, input stim_t s);
    if (a == 5'd0) return 32'd0;
    if (s.we && s.wa == a) return s.d;
    return m_mem[a];
  endfunction

  function automatic logic m_bz(input logic [4:0] a, input stim_t s);
    return (a != 5'd0) && m_busy[a] && !(s.we && s.wa == a);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'd0;
      m_busy[i] = 0;
    end
    m_o1 = 32'd0;
    m_o2 = 32'd0;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    if (have_pend) q_out.push_back(pend);
    #1;
    in0 = s.d; w = s.wa; we = s.we; r1 = s.ra1; re1 = s.e1;
    r2 = s.ra2; re2 = s.e2; issue = s.iss; id = s.idd;
    q_busy.push_back({m_bz(s.ra1, s), m_bz(s.ra2, s)});
    if (s.e1) m_o1 = m_rd(s.ra1, s);
    if (s.e2) m_o2 = m_rd(s.ra2, s);
    if (s.we && s.wa != 5'd0) m_mem[s.wa] = s.d;
    if (s.we) m_busy[s.wa] = 0;
    if (s.iss && s.idd != 5'd0) m_busy[s.idd] = 1;
    pend.o1 = m_o1;
    pend.o2 = m_o2;
    have_pend = 1;
  endtask

  // Drop reset between edges; registered outputs must clear without a clock.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    we = 0; re1 = 0; re2 = 0; issue = 0;
    rst_n = 1'b0;
    have_pend = 0;
    #1;
    chk("rst_out1", out1, 32'd0);
    chk("rst_out2", out2, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    repeat (2) @(negedge clk);
    m_clear();
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] ra();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    if (q_out.size() > 0) begin
      out_t e;
      e = q_out.pop_front();
      chk("out1", out1, e.o1);
      chk("out2", out2, e.o2);
    end
    if (q_busy.size() > 0) begin
      logic [1:0] b;
      b = q_busy.pop_front();
      chk("busy1", {31'd0, busy1}, {31'd0, b[1]});
      chk("busy2", {31'd0, busy2}, {31'd0, b[0]});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in0 = '0; w = '0; we = 0; r1 = '0; re1 = 0; r2 = '0; re2 = 0; issue = 0; id = '0;
    m_clear();
    #1;
    chk("init_out1", out1, 32'd0);
    chk("init_out2", out2, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reads after reset, then a write and read-back, then reset mid-burst.
    step(st(0, 0, 0, 1, 5'd3, 1, 5'd31, 0, 0));
    step(st(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 5'd12));
    step(st(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 0));
    step(st(0, 0, 0, 0, 5'd12, 1, 5'd12, 0, 0));
    mid_reset();

    // Same-cycle bypass over a stale value.
    step(st(1, 5'd7, 32'h0000AAAA, 0, 0, 0, 0, 0, 0));
    step(st(1, 5'd7, 32'h00001234, 1, 5'd7, 1, 5'd7, 0, 0));
    step(st(0, 0, 0, 1, 5'd7, 0, 0, 0, 0));

    // R0 is hardwired: write discarded, bypass suppressed, never busy.
    step(st(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 0, 0, 0));
    step(st(0, 0, 0, 1, 5'd0, 0, 0, 1, 5'd0));
    step(st(0, 0, 0, 1, 5'd0, 0, 0, 0, 0));

    // Scoreboard set, bypass-clear, and set-wins collision on index 9.
    step(st(0, 0, 0, 0, 0, 0, 5'd9, 1, 5'd9));
    step(st(0, 0, 0, 0, 0, 0, 5'd9, 1, 5'd9));
    step(st(0, 0, 0, 0, 0, 0, 5'd9, 0, 0));
    step(st(1, 5'd9, 32'h99, 0, 0, 1, 5'd9, 0, 0));
    step(st(0, 0, 0, 0, 0, 0, 5'd9, 0, 0));
    step(st(1, 5'd9, 32'h98, 0, 0, 0, 5'd9, 1, 5'd9));
    step(st(0, 0, 0, 0, 0, 0, 5'd9, 0, 0));

    // Read-enable low holds the output while the address moves.
    step(st(1, 5'd2, 32'h22222222, 0, 0, 0, 0, 0, 0));
    step(st(1, 5'd4, 32'h44444444, 1, 5'd2, 0, 0, 0, 0));
    step(st(0, 0, 0, 0, 5'd4, 0, 0, 0, 0));
    step(st(0, 0, 0, 0, 5'd4, 0, 0, 0, 0));

    for (int n = 0; n < 600; n++) begin
      step(st(1'($urandom_range(0, 1)), ra(), $urandom,
              1'($urandom_range(0, 3) != 0), ra(),
              1'($urandom_range(0, 3) != 0), ra(),
              1'($urandom_range(0, 2) == 0), ra()));
      if (n == 300) mid_reset();
    end

    @(posedge clk);
    if (have_pend) q_out.push_back(pend);
    have_pend = 0;
    repeat (2) @(negedge clk);
    chk("drain_out", 32'(q_out.size()), 32'd0);
    chk("drain_busy", 32'(q_busy.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
